// File: rtl/flex_pipe_register_if.sv
// Valid/ready bus for flex_pipe_register: upstream
// word in, downstream word out, one bundle.
interface flex_pipe_register_if #(
    parameter int WIDTH = 64
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_v_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_v_data;

    modport slave (
        input  i_valid,
        input  i_v_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_v_data
    );

    modport master (
        output i_valid,
        output i_v_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_v_data
    );
endinterface

// File: rtl/flex_pipe_register.sv
// Elastic DEPTH-stage pipeline register with bubble collapse.
// Optional synchronous flush port: define FLEX_PIPE_FLUSH_EN.
module flex_pipe_register #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
`ifdef FLEX_PIPE_FLUSH_EN
    input  logic                 i_flush,
`endif
    flex_pipe_register_if.slave  bus,
    output logic [CW-1:0]        o_count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] vin;
    logic [WIDTH-1:0] din [DEPTH];
    logic             flush;
    logic             in_xfer;
    logic             out_xfer;
    logic             r;

`ifdef FLEX_PIPE_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // A stage can load when it is empty or everything after it moves.
    always_comb begin
        r = bus.i_ready;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            r = !valid_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        vin[0] = bus.i_valid;
        din[0] = bus.i_v_data;
        for (int k = 1; k < DEPTH; k++) begin
            vin[k] = valid_q[k-1];
            din[k] = data_q[k-1];
        end
    end

    assign in_xfer  = bus.i_valid && rdy[0] && !flush;
    assign out_xfer = valid_q[DEPTH-1] && bus.i_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = vin[k];
                    if (vin[k]) begin
                        data_d[k] = din[k];
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_ready  = rdy[0] && !flush;
    assign bus.o_valid  = valid_q[DEPTH-1] && !flush;
    assign bus.o_v_data = data_q[DEPTH-1];
    assign o_count      = count_q;

endmodule
